// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared state encoding and default geometry for the MEM-stage SRAM controller.
package arm_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int          DEF_WAIT_CYCLES = 5;
    localparam int          SRAM_ADDR_W     = 17;
    localparam int          DATA_W          = 32;
endpackage

// File: rtl/sram_read_buf.sv
// sram_read_buf: one-entry read buffer (valid, word address, data) used when SRAM_READ_BUF_EN is defined.
import arm_mem_pkg::*;
module sram_read_buf #(
    parameter int ADDR_W = SRAM_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fill,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_upd_addr,
    input  logic [DATA_W-1:0] i_upd_data,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_addr  <= i_upd_addr;
            r_data  <= i_upd_data;
        end else if (i_wr && r_valid && r_addr == i_upd_addr) begin
            r_data  <= i_upd_data;
        end
    end
    assign o_hit  = r_valid && (r_addr == i_lookup_addr);
    assign o_data = r_data;
endmodule

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: MEM-stage to 32-bit SRAM bridge with pipeline freeze and one-cycle ready pulse.
// Optional one-entry read buffer enabled by defining SRAM_READ_BUF_EN.
import arm_mem_pkg::*;
module sram_mem_controller #(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int          ADDR_W      = SRAM_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    input  logic [31:0]       i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    output logic              o_freeze,
    output logic              o_sram_we_n,
    output logic [ADDR_W-1:0] o_sram_addr,
    inout  wire  [DATA_W-1:0] io_sram_dq
);
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_wr;
    logic              r_dq_oe;
    logic [DATA_W-1:0] r_wdata;
    logic [31:0]       w_off;
    logic [ADDR_W-1:0] w_sram_addr;
    logic              w_last;
    logic              w_hit;
    logic [DATA_W-1:0] w_buf_data;
    assign w_off       = i_addr - BASE_ADDR;
    assign w_sram_addr = w_off[ADDR_W+1:2];
    assign w_last      = (r_state == ACCESS) && (r_cnt == LAST);
    assign o_freeze    = (i_wr_en | i_rd_en) & ~o_ready;
    assign io_sram_dq  = r_dq_oe ? r_wdata : 'z;
`ifdef SRAM_READ_BUF_EN
    logic w_buf_hit;
    sram_read_buf #(.ADDR_W(ADDR_W)) u_read_buf (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_fill        (w_last & ~r_wr),
        .i_wr          (w_last & r_wr),
        .i_upd_addr    (o_sram_addr),
        .i_upd_data    (r_wr ? r_wdata : io_sram_dq),
        .i_lookup_addr (w_sram_addr),
        .o_hit         (w_buf_hit),
        .o_data        (w_buf_data)
    );
    assign w_hit = (r_state == IDLE) & i_rd_en & ~i_wr_en & w_buf_hit;
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = '0;
`endif
    // WE_N and DQ enable drop on the same edge that ends ACCESS, so the bus is released before DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_dq_oe     <= 1'b0;
            r_wdata     <= '0;
            o_rdata     <= '0;
            o_ready     <= 1'b0;
            o_sram_we_n <= 1'b1;
            o_sram_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    o_ready <= 1'b0;
                    if (w_hit) begin
                        r_state <= DONE;
                        o_ready <= 1'b1;
                        o_rdata <= w_buf_data;
                    end else if (i_wr_en | i_rd_en) begin
                        r_state     <= ACCESS;
                        r_cnt       <= '0;
                        r_wr        <= i_wr_en;
                        r_wdata     <= i_wdata;
                        r_dq_oe     <= i_wr_en;
                        o_sram_we_n <= ~i_wr_en;
                        o_sram_addr <= w_sram_addr;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_state     <= DONE;
                        o_ready     <= 1'b1;
                        o_sram_we_n <= 1'b1;
                        r_dq_oe     <= 1'b0;
                        if (!r_wr) o_rdata <= io_sram_dq;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: scoreboard bench with an SRAM model and a word-level reference memory.
module tb_sram_mem_controller;
    localparam int W = 5;
    typedef struct {
        logic        rd;
        logic [31:0] data;
        int          issue;
        int          lat;
    } exp_t;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        i_wr_en = 0, i_rd_en = 0;
    logic [31:0] i_addr = 0, i_wdata = 0;
    logic [31:0] o_rdata;
    logic        o_ready, o_freeze, o_sram_we_n;
    logic [16:0] o_sram_addr;
    wire  [31:0] sram_dq;
    logic [31:0] sram [0:131071];
    logic [31:0] mem_ref [int];
    logic [31:0] last_rd = 0;
    exp_t        q[$];
    int          cyc = 0, checks = 0, errors = 0;
    logic        bv = 0;
    logic [16:0] ba = 0;

    sram_mem_controller dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(i_wr_en), .i_rd_en(i_rd_en),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_ready(o_ready),
        .o_freeze(o_freeze), .o_sram_we_n(o_sram_we_n), .o_sram_addr(o_sram_addr),
        .io_sram_dq(sram_dq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] dflt(input logic [16:0] a);
        return 32'hC0DE0000 ^ {15'd0, a};
    endfunction

    function automatic logic [31:0] rd_ref(input logic [16:0] a);
        return mem_ref.exists(int'(a)) ? mem_ref[int'(a)] : dflt(a);
    endfunction

    // SRAM model: drives the bus whenever it is not being written
    assign sram_dq = o_sram_we_n ? sram[o_sram_addr] : 32'bz;
    always @(posedge clk) if (!o_sram_we_n) sram[o_sram_addr] <= sram_dq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("dq_no_contention", 32'(!$isunknown(sram_dq)), 32'd1);
            if (o_ready) begin
                if (q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk(e.rd ? "load_data" : "rdata_hold_on_write", o_rdata, e.data);
                    chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                end
            end
        end
    end

    task automatic req(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        logic [16:0] ea;
        logic        is_rd, hit, fz_ok;
        int          n, wl;
        ea    = 17'((a - 32'd1024) >> 2);
        is_rd = rd & ~wr;
        hit   = 1'b0;
`ifdef SRAM_READ_BUF_EN
        hit = is_rd & bv & (ba == ea);
        if (is_rd) begin bv = 1'b1; ba = ea; end
`endif
        @(negedge clk);
        i_wr_en = wr; i_rd_en = rd; i_addr = a; i_wdata = d;
        if (wr) mem_ref[int'(ea)] = d;
        else last_rd = rd_ref(ea);
        q.push_back('{is_rd, last_rd, cyc, hit ? 1 : W + 1});
        n = 0; wl = 0; fz_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && !hit) chk("sram_addr", 32'(o_sram_addr), 32'(ea));
            if (!o_ready) begin
                if (!o_freeze) fz_ok = 1'b0;
                if (!o_sram_we_n) wl++;
            end
        end while (!o_ready && n < 40);
        chk("ready_seen", 32'(o_ready), 32'd1);
        chk("freeze_high_until_ready", 32'(fz_ok), 32'd1);
        chk("freeze_low_on_ready", 32'(o_freeze), 32'd0);
        chk("we_n_low_cycles", 32'(wl), wr ? 32'(W) : 32'd0);
    endtask

    task automatic idle(input int g);
        @(negedge clk);
        i_wr_en = 0; i_rd_en = 0;
        repeat (g) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) sram[i] = dflt(17'(i));
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(o_ready), 32'd0);
        chk("reset_we_n", 32'(o_sram_we_n), 32'd1);
        chk("reset_sram_addr", 32'(o_sram_addr), 32'd0);
        chk("reset_rdata", o_rdata, 32'd0);
        chk("reset_freeze", 32'(o_freeze), 32'd0);
        rst_n = 1;
        idle(1);
        // abandon a write during its second ACCESS cycle
        i_wr_en = 1; i_addr = 1028; i_wdata = 32'h0BADF00D;
        repeat (2) @(negedge clk);
        chk("midwrite_we_n_low", 32'(o_sram_we_n), 32'd0);
        rst_n = 0;
        #1;
        chk("rst_we_n", 32'(o_sram_we_n), 32'd1);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_freeze_follows_req", 32'(o_freeze), 32'd1);
        chk("rst_dq_released", sram_dq, sram[o_sram_addr]);
        q.delete(); bv = 0; last_rd = 0;
        i_wr_en = 0;
        #1;
        chk("rst_freeze_no_req", 32'(o_freeze), 32'd0);
        @(negedge clk); rst_n = 1;
        idle(1);
        chk("post_rst_ready", 32'(o_ready), 32'd0);
        req(1, 0, 1028, 32'h55AA55AA);
        idle(1);
        req(1, 0, 1024, 32'hDEADBEEF);
        idle(2);
        req(0, 1, 1024, 0);
        idle(1);
        req(0, 1, 1024 + 4 * 32'h1FFFF, 0);
        idle(1);
        req(0, 1, 1026, 0);
        idle(1);
        req(1, 1, 1032, 32'h12345678);
        idle(1);
        req(0, 1, 1032, 0);
        idle(1);
        req(1, 0, 1036, 32'hCAFEF00D);
        req(0, 1, 1044, 0);
        req(0, 1, 1036, 0);
        idle(1);
        req(0, 1, 1040, 0);
        idle(1);
        req(0, 1, 1040, 0);
        idle(1);
        req(1, 0, 1040, 32'h1);
        idle(1);
        req(0, 1, 1040, 0);
        idle(1);
        for (int i = 0; i < 60; i++) begin
            int op;
            logic [31:0] a;
            op = int'($urandom_range(0, 2));
            a  = 32'd1024 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
            req(op != 1, op != 0, a, $urandom);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 2)));
        end
        idle(4);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
